// File: rtl/iter_multiplier_if.sv
// Request/response bundle between Execute and the iterative multiplier.
//   master : Execute side, drives the request and samples the result.
//   slave  : multiplier side.
// Request : start, signed_mode, long_mode, acc_en, acc_lo, acc_hi, in0, in1
// Response: busy, done, result_lo, result_hi, flag_n, flag_z
interface iter_multiplier_if #(
  parameter int W = 32
);
  logic         start;
  logic         signed_mode;
  logic         long_mode;
  logic         acc_en;
  logic [W-1:0] acc_lo;
  logic [W-1:0] acc_hi;
  logic [W-1:0] in0;
  logic [W-1:0] in1;
  logic         busy;
  logic         done;
  logic [W-1:0] result_lo;
  logic [W-1:0] result_hi;
  logic         flag_n;
  logic         flag_z;

  modport master (
    output start, signed_mode, long_mode, acc_en, acc_lo, acc_hi, in0, in1,
    input  busy, done, result_lo, result_hi, flag_n, flag_z
  );

  modport slave (
    input  start, signed_mode, long_mode, acc_en, acc_lo, acc_hi, in0, in1,
    output busy, done, result_lo, result_hi, flag_n, flag_z
  );
endinterface

// File: rtl/iter_multiplier.sv
// Iterative multiply / multiply-accumulate unit (MUL, MLA, UMULL, UMLAL,
// SMULL, SMLAL). Retires BPC multiplier bits per RUN cycle on the operand
// magnitudes and stops as soon as the remaining multiplier bits are zero;
// sign and accumulator are applied in a single FIN cycle.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - iter_multiplier_if slave: request fields in, busy/done/results/flags out
// Parameters:
//   W    - operand width
//   BPC  - multiplier bits per cycle (1, 2 or 4; must divide W)
module iter_multiplier #(
  parameter int W   = 32,
  parameter int BPC = 2
) (
  input  logic               clk,
  input  logic               rst,
  iter_multiplier_if.slave   bus
);

  localparam int W2 = 2 * W;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state, state_next;

  // Latched request
  logic          neg;
  logic          long_q;
  logic          acc_en_q;
  logic [W-1:0]  acc_lo_q;
  logic [W-1:0]  acc_hi_q;

  // Shift-and-add datapath
  logic [W-1:0]  mplier;
  logic [W2-1:0] mcand;
  logic [W2-1:0] prod;

  // Registered outputs
  logic          done_q;
  logic [W-1:0]  result_lo_q;
  logic [W-1:0]  result_hi_q;
  logic          flag_n_q;
  logic          flag_z_q;

  // Operand magnitudes: only a signed long multiply works on |x|; the
  // W-bit negate of the most negative value yields 2^(W-1) as unsigned.
  logic          take_abs;
  logic [W-1:0]  abs0;
  logic [W-1:0]  abs1;

  always_comb begin
    take_abs = bus.signed_mode & bus.long_mode;
    abs0     = (take_abs && bus.in0[W-1]) ? (W'(0) - bus.in0) : bus.in0;
    abs1     = (take_abs && bus.in1[W-1]) ? (W'(0) - bus.in1) : bus.in1;
  end

  // Sum of the BPC shifted partial products selected by the low multiplier bits.
  logic [W2-1:0] partial;

  // NOTE: combinational blocks use blocking '=' and give every target a
  // default first, so the loop accumulates in order and no latch is inferred.
  always_comb begin
    partial = '0;
    for (int i = 0; i < BPC; i++) begin
      if (mplier[i]) partial = partial + (mcand << i);
    end
  end

  // FIN arithmetic: restore the sign, then add the accumulator modulo 2^(2W).
  logic [W2-1:0] prod_signed;
  logic [W2-1:0] acc_word;
  logic [W2-1:0] sum;

  always_comb begin
    prod_signed = neg ? (W2'(0) - prod) : prod;
    acc_word    = '0;
    if (acc_en_q) acc_word = long_q ? {acc_hi_q, acc_lo_q} : {{W{1'b0}}, acc_lo_q};
    sum         = prod_signed + acc_word;
  end

  // NOTE: clocked state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (mplier == '0) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every datapath register, not only the control state, is cleared on
  // reset so an aborted operation leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg         <= 1'b0;
      long_q      <= 1'b0;
      acc_en_q    <= 1'b0;
      acc_lo_q    <= '0;
      acc_hi_q    <= '0;
      mplier      <= '0;
      mcand       <= '0;
      prod        <= '0;
      done_q      <= 1'b0;
      result_lo_q <= '0;
      result_hi_q <= '0;
      flag_n_q    <= 1'b0;
      flag_z_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            neg      <= take_abs & (bus.in0[W-1] ^ bus.in1[W-1]);
            long_q   <= bus.long_mode;
            acc_en_q <= bus.acc_en;
            acc_lo_q <= bus.acc_lo;
            acc_hi_q <= bus.acc_hi;
            mplier   <= abs0;
            mcand    <= {{W{1'b0}}, abs1};
            prod     <= '0;
          end
        end
        RUN: begin
          // An exhausted multiplier costs one extra cycle with no add.
          if (mplier != '0) begin
            prod   <= prod + partial;
            mplier <= mplier >> BPC;
            mcand  <= mcand << BPC;
          end
        end
        FIN: begin
          result_lo_q <= sum[W-1:0];
          result_hi_q <= long_q ? sum[W2-1:W] : '0;
          flag_n_q    <= long_q ? sum[W2-1] : sum[W-1];
          flag_z_q    <= long_q ? (sum == '0) : (sum[W-1:0] == '0);
          done_q      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.result_lo = result_lo_q;
  assign bus.result_hi = result_hi_q;
  assign bus.flag_n    = flag_n_q;
  assign bus.flag_z    = flag_z_q;

endmodule
